// File: rtl/pipeline_ctrl_pkg.sv
// Shared CPU control definitions: pipeline-control FSM encoding and default widths.
package pipeline_ctrl_pkg;

    localparam int DEF_REG_INDEX_W = 4;
    localparam int DEF_CNT_W       = 16;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: the load in EX writes a register the ID instruction reads.
module hazard_detect #(
    parameter int REG_INDEX_BIT_WIDTH = 4
) (
    input  logic                           ex_is_load,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] ex_dst_ind,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] id_src1_ind,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] id_src2_ind,
    input  logic                           id_src1_used,
    input  logic                           id_src2_used,
    output logic                           load_use
);

    // Register 0 is compared like any other index.
    assign load_use = ex_is_load &&
                      ((id_src1_used && (id_src1_ind == ex_dst_ind)) ||
                       (id_src2_used && (id_src2_ind == ex_dst_ind)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: stage enables/flushes, memory-wait FSM and saturating perf counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_INDEX_BIT_WIDTH = DEF_REG_INDEX_W,
    parameter int CNT_WIDTH           = DEF_CNT_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] id_src1_ind,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] id_src2_ind,
    input  logic                           id_src1_used,
    input  logic                           id_src2_used,
    input  logic                           ex_is_load,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] ex_dst_ind,
    input  logic                           ex_mispredict,
    input  logic                           mem_req,
    input  logic                           mem_ready,
    output logic                           pc_en,
    output logic                           ifid_en,
    output logic                           idex_en,
    output logic                           exmem_en,
    output logic                           memwb_en,
    output logic                           ifid_flush,
    output logic                           idex_flush,
    output logic                           exmem_flush,
    output logic                           memwb_flush,
    output logic                           pc_sel_target,
    output logic [CNT_WIDTH-1:0]           stall_cnt,
    output logic [CNT_WIDTH-1:0]           flush_cnt
);

    ctrl_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic                 load_use;
    logic                 mem_wait;
    logic                 stall_now;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    hazard_detect #(
        .REG_INDEX_BIT_WIDTH(REG_INDEX_BIT_WIDTH)
    ) u_hazard_detect (
        .ex_is_load  (ex_is_load),
        .ex_dst_ind  (ex_dst_ind),
        .id_src1_ind (id_src1_ind),
        .id_src2_ind (id_src2_ind),
        .id_src1_used(id_src1_used),
        .id_src2_used(id_src2_used),
        .load_use    (load_use)
    );

    always_comb begin
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        memwb_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        memwb_flush   = 1'b0;
        pc_sel_target = 1'b0;
        stall_now     = 1'b0;
        flush_cnt_d   = flush_cnt_q;
        stall_cnt_d   = stall_cnt_q;

        // The ready cycle of a pending access is evaluated exactly like RUN.
        mem_wait = !mem_ready && ((state_q == MEM_WAIT) || mem_req);
        state_d  = mem_wait ? MEM_WAIT : RUN;

        if (reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (mem_wait) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
            stall_now   = 1'b1;
        end else if (ex_mispredict) begin
            pc_sel_target = 1'b1;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            flush_cnt_d   = sat_inc(flush_cnt_q);
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            stall_now  = 1'b1;
        end

        if (stall_now) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: driver pushes model predictions, negedge monitor compares.
module tb_pipeline_ctrl;

    localparam int RW = 4;
    localparam int CW = 16;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] id_src1_ind, id_src2_ind, ex_dst_ind;
    logic          id_src1_used, id_src2_used, ex_is_load, ex_mispredict;
    logic          mem_req, mem_ready;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_sel_target;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipeline_ctrl #(.REG_INDEX_BIT_WIDTH(RW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .id_src1_ind(id_src1_ind), .id_src2_ind(id_src2_ind),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
        .ex_is_load(ex_is_load), .ex_dst_ind(ex_dst_ind),
        .ex_mispredict(ex_mispredict), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .pc_sel_target(pc_sel_target), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct packed {
        logic          rst;
        logic          req;
        logic          rdy;
        logic          misp;
        logic          load;
        logic          used1;
        logic          used2;
        logic [RW-1:0] src1;
        logic [RW-1:0] src2;
        logic [RW-1:0] dst;
    } stim_t;

    typedef struct {
        logic [9:0] ctrl;   // {5 enables pc..memwb, 4 flushes ifid..memwb, pc_sel_target}
        int         stall;
        int         flush;
        bit         chk_cnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: "waiting on memory" flag plus two integer counters.
    bit m_wait  = 1'b0;
    int m_stall = 0;
    int m_flush = 0;
    bit m_known = 1'b0;

    task automatic drive(input stim_t s);
        exp_t       e;
        logic [4:0] en;
        logic [3:0] fl;
        logic       sel;
        bit         frozen, hazard;
        @(posedge clk);
        #1;
        reset = s.rst;           mem_req = s.req;        mem_ready = s.rdy;
        ex_mispredict = s.misp;  ex_is_load = s.load;    ex_dst_ind = s.dst;
        id_src1_used = s.used1;  id_src2_used = s.used2;
        id_src1_ind = s.src1;    id_src2_ind = s.src2;

        frozen = !s.rdy && (m_wait || s.req);
        hazard = s.load && ((s.used1 && s.src1 == s.dst) || (s.used2 && s.src2 == s.dst));
        sel = 1'b0;
        if (s.rst)        begin en = 5'b00000; fl = 4'b1111; end
        else if (frozen)  begin en = 5'b00001; fl = 4'b0001; end
        else if (s.misp)  begin en = 5'b11111; fl = 4'b1100; sel = 1'b1; end
        else if (hazard)  begin en = 5'b00111; fl = 4'b0100; end
        else              begin en = 5'b11111; fl = 4'b0000; end

        e.ctrl = {en, fl, sel};
        e.stall = m_stall;
        e.flush = m_flush;
        e.chk_cnt = m_known;
        q.push_back(e);

        if (s.rst) begin
            m_wait = 1'b0; m_stall = 0; m_flush = 0; m_known = 1'b1;
        end else begin
            m_wait = frozen;
            if (!en[4] && m_stall < CNT_MAX) m_stall++;
            if (sel && m_flush < CNT_MAX) m_flush++;
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            checks++;
            if ({pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_sel_target} !== mon_e.ctrl) begin
                errors++;
                $display("FAIL ctrl @%0t: got %b expected %b", $time,
                         {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                          ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_sel_target}, mon_e.ctrl);
            end
            if (mon_e.chk_cnt) begin
                checks += 2;
                if (stall_cnt !== CW'(mon_e.stall)) begin
                    errors++;
                    $display("FAIL stall_cnt @%0t: got %0d expected %0d", $time, stall_cnt, mon_e.stall);
                end
                if (flush_cnt !== CW'(mon_e.flush)) begin
                    errors++;
                    $display("FAIL flush_cnt @%0t: got %0d expected %0d", $time, flush_cnt, mon_e.flush);
                end
            end
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rdy = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst   = ($urandom_range(0, 149) == 0);
        s.req   = ($urandom_range(0, 3) == 0);
        s.rdy   = ($urandom_range(0, 2) != 0);
        s.misp  = ($urandom_range(0, 5) == 0);
        s.load  = ($urandom_range(0, 2) == 0);
        s.used1 = 1'($urandom_range(0, 1));
        s.used2 = 1'($urandom_range(0, 1));
        s.src1  = RW'($urandom_range(0, 3));
        s.src2  = RW'($urandom_range(0, 3));
        s.dst   = RW'($urandom_range(0, 3));
        return s;
    endfunction

    initial begin
        stim_t s;
        reset = 1'b1; mem_req = 1'b0; mem_ready = 1'b1; ex_mispredict = 1'b0;
        ex_is_load = 1'b0; ex_dst_ind = '0; id_src1_used = 1'b0; id_src2_used = 1'b0;
        id_src1_ind = '0; id_src2_ind = '0;

        s = idle(); s.rst = 1'b1;
        repeat (2) drive(s);
        drive(idle());

        // Load-use on source 2, then the same with source 2 unused.
        s = idle(); s.load = 1'b1; s.dst = 4'd5; s.src2 = 4'd5; s.used2 = 1'b1; s.src1 = 4'd3; s.used1 = 1'b1;
        drive(s);
        s.used2 = 1'b0;
        drive(s);
        // Register 0 is not special.
        s = idle(); s.load = 1'b1; s.dst = 4'd0; s.src1 = 4'd0; s.used1 = 1'b1;
        drive(s);

        s = idle(); s.misp = 1'b1;
        drive(s);
        drive(idle());

        // Three-cycle memory wait, then ready.
        s = idle(); s.req = 1'b1; s.rdy = 1'b0;
        repeat (3) drive(s);
        s.rdy = 1'b1;
        drive(s);
        drive(idle());

        // Wait overlapping mispredict and load-use.
        s = idle(); s.req = 1'b1; s.rdy = 1'b0; s.misp = 1'b1;
        s.load = 1'b1; s.dst = 4'd7; s.src1 = 4'd7; s.used1 = 1'b1;
        repeat (2) drive(s);
        s.rdy = 1'b1;
        drive(s);
        drive(idle());

        // Reset while waiting on memory.
        s = idle(); s.req = 1'b1; s.rdy = 1'b0;
        repeat (2) drive(s);
        s.rst = 1'b1;
        drive(s);
        s = idle(); s.rdy = 1'b0;
        drive(s);
        drive(idle());

        repeat (2000) drive(rand_stim());

        // Long load-use run pushes stall_cnt into saturation.
        s = idle(); s.rst = 1'b1;
        drive(s);
        s = idle(); s.load = 1'b1; s.dst = 4'd9; s.src1 = 4'd9; s.used1 = 1'b1;
        repeat (70000) drive(s);
        repeat (3) drive(idle());

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
